// File: rtl/display_unit_if.sv
// display_unit_if -- signal bundle between the core stage and the display unit.
//
// Signals:
//   IN_value       [15:0] unsigned magnitude to show
//   IN_off_number  [2:0]  count of blanked leading digits (5..7 act as 4)
//   IN_neg_ans            show a minus sign in the rightmost blanked position
//   IN_less_than          compare flag (drives dp of digit 0 when enabled)
//   IN_zero               zero flag (drives dp of digit 1 when enabled)
//   OUT_seg        [7:0]  active-low segments {dp,g,f,e,d,c,b,a}
//   OUT_an         [3:0]  active-low digit enables, bit 3 = leftmost digit
//   OUT_busy              high while a BCD conversion is in progress
//
// Modports: master = the producer of the values (core stage / bench),
//           slave  = the display unit.
`timescale 1ns/1ps
interface display_unit_if;
  logic [15:0] IN_value;
  logic [2:0]  IN_off_number;
  logic        IN_neg_ans;
  logic        IN_less_than;
  logic        IN_zero;
  logic [7:0]  OUT_seg;
  logic [3:0]  OUT_an;
  logic        OUT_busy;

  modport master (
    output IN_value, IN_off_number, IN_neg_ans, IN_less_than, IN_zero,
    input  OUT_seg, OUT_an, OUT_busy
  );

  modport slave (
    input  IN_value, IN_off_number, IN_neg_ans, IN_less_than, IN_zero,
    output OUT_seg, OUT_an, OUT_busy
  );
endinterface

// File: rtl/display_unit.sv
// display_unit -- four-digit multiplexed seven-segment driver.
//
// Converts a 16-bit magnitude to BCD with a sequential shift-add-3 engine
// (16 cycles), then loads the four digit patterns in one cycle. The digits
// are scanned one slot at a time, leftmost first, each slot lasting SCAN_DIV
// clock cycles. Values above 9999, or a negative result with no blank
// position to hold the sign, show "E" on all four digits.
//
// Ports:
//   IN_clk    rising-edge clock
//   IN_rst_n  asynchronous active-low reset
//   bus       display_unit_if.slave (value/flags in, segments/anodes/busy out)
//
// Parameter:
//   SCAN_DIV  clock cycles per digit slot (default 50000)
//
// Optional feature, macro DISP_FLAG_DP_EN:
//   defined   -> dp of digit 0 follows IN_less_than, dp of digit 1 follows
//                IN_zero (both live, not tied to the conversion)
//   undefined -> both flags ignored, every dp stays off
`timescale 1ns/1ps
module display_unit #(
  parameter logic [15:0] SCAN_DIV = 16'd50000
) (
  input  logic         IN_clk,
  input  logic         IN_rst_n,
  display_unit_if.slave bus
);

  localparam logic [6:0] SEG_E     = 7'h06;
  localparam logic [6:0] SEG_MINUS = 7'h3F;
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CONV,
    ST_LOAD
  } state_t;

  state_t state_reg, state_next;

  // Input sample registers and the set most recently handed to the converter
  logic [15:0] value_reg;
  logic [2:0]  off_reg;
  logic        neg_reg;
  logic [15:0] last_value_reg;
  logic [2:0]  last_off_reg;
  logic        last_neg_reg;

  // Shift-add-3 engine
  logic [15:0] bin_reg;
  logic [15:0] bcd_reg;
  logic [15:0] bcd_adj;
  logic [3:0]  step_reg;

  // Displayed digit patterns, 7 bits each {g..a}, digit 0 in the low bits
  logic [27:0] digits_reg;
  logic [27:0] load_pat;

  // Scan
  logic [15:0] div_reg;
  logic [1:0]  slot_reg;

  logic        input_changed;
  logic        busy;
  logic [2:0]  off_eff;
  logic        show_err;
  logic [6:0]  seg_sel;
  logic        dp;

  function automatic logic [6:0] seg7(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'h40;
      4'd1:    s = 7'h79;
      4'd2:    s = 7'h24;
      4'd3:    s = 7'h30;
      4'd4:    s = 7'h19;
      4'd5:    s = 7'h12;
      4'd6:    s = 7'h02;
      4'd7:    s = 7'h78;
      4'd8:    s = 7'h00;
      4'd9:    s = 7'h10;
      default: s = SEG_BLANK;
    endcase
    return s;
  endfunction

  assign input_changed = {value_reg, off_reg, neg_reg} !=
                         {last_value_reg, last_off_reg, last_neg_reg};

  // ---------------- FSM ----------------
  always_ff @(posedge IN_clk or negedge IN_rst_n) begin
    if (!IN_rst_n) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    busy       = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (input_changed) begin
          state_next = ST_CONV;
        end
      end
      ST_CONV: begin
        busy = 1'b1;
        if (step_reg == 4'd15) begin
          state_next = ST_LOAD;
        end
      end
      ST_LOAD: begin
        busy       = 1'b1;
        state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  assign bus.OUT_busy = busy;

  // ---------------- Conversion datapath ----------------
  // Per-nibble add-3 before each left shift (double dabble). Only four BCD
  // digits are kept; anything above 9999 is shown as "E" so the lost fifth
  // digit never matters.
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_adj
      assign bcd_adj[gi*4 +: 4] = (bcd_reg[gi*4 +: 4] >= 4'd5) ?
                                  bcd_reg[gi*4 +: 4] + 4'd3 :
                                  bcd_reg[gi*4 +: 4];
    end
  endgenerate

  assign off_eff  = (last_off_reg > 3'd4) ? 3'd4 : last_off_reg;
  assign show_err = (last_value_reg > 16'd9999) || (last_neg_reg && (off_eff == 3'd0));

  // Position gi is blanked when gi >= 4 - off_eff; the minus sign goes in
  // the lowest blanked position (gi == 4 - off_eff).
  generate
    for (gi = 0; gi < 4; gi++) begin : g_pat
      logic [2:0] pos_sum;
      assign pos_sum = 3'(gi) + off_eff;
      assign load_pat[gi*7 +: 7] =
        show_err            ? SEG_E :
        (pos_sum >= 3'd4)   ? ((last_neg_reg && pos_sum == 3'd4) ? SEG_MINUS : SEG_BLANK) :
                              seg7(bcd_reg[gi*4 +: 4]);
    end
  endgenerate

  always_ff @(posedge IN_clk or negedge IN_rst_n) begin
    if (!IN_rst_n) begin
      value_reg      <= 16'h0;
      off_reg        <= 3'd4;
      neg_reg        <= 1'b0;
      last_value_reg <= 16'h0;
      last_off_reg   <= 3'd4;
      last_neg_reg   <= 1'b0;
      bin_reg        <= 16'h0;
      bcd_reg        <= 16'h0;
      step_reg       <= 4'd0;
      digits_reg     <= {4{SEG_BLANK}};
    end else begin
      // Sampling runs every cycle; changes arriving during a conversion are
      // picked up by the comparison as soon as the FSM is back in IDLE.
      value_reg <= bus.IN_value;
      off_reg   <= bus.IN_off_number;
      neg_reg   <= bus.IN_neg_ans;

      case (state_reg)
        ST_IDLE: begin
          if (input_changed) begin
            last_value_reg <= value_reg;
            last_off_reg   <= off_reg;
            last_neg_reg   <= neg_reg;
            bin_reg        <= value_reg;
            bcd_reg        <= 16'h0;
            step_reg       <= 4'd0;
          end
        end
        ST_CONV: begin
          bcd_reg  <= {bcd_adj[14:0], bin_reg[15]};
          bin_reg  <= {bin_reg[14:0], 1'b0};
          step_reg <= step_reg + 4'd1;
        end
        ST_LOAD: begin
          digits_reg <= load_pat;
        end
        default: ;
      endcase
    end
  end

  // ---------------- Scan ----------------
  always_ff @(posedge IN_clk or negedge IN_rst_n) begin
    if (!IN_rst_n) begin
      div_reg  <= 16'h0;
      slot_reg <= 2'd3;
    end else if (div_reg == SCAN_DIV - 16'd1) begin
      div_reg  <= 16'h0;
      slot_reg <= slot_reg - 2'd1;   // 3 -> 2 -> 1 -> 0 -> 3
    end else begin
      div_reg <= div_reg + 16'd1;
    end
  end

  always_comb begin
    seg_sel = SEG_BLANK;
    case (slot_reg)
      2'd0: seg_sel = digits_reg[6:0];
      2'd1: seg_sel = digits_reg[13:7];
      2'd2: seg_sel = digits_reg[20:14];
      2'd3: seg_sel = digits_reg[27:21];
      default: seg_sel = SEG_BLANK;
    endcase
  end

`ifdef DISP_FLAG_DP_EN
  assign dp = ~(((slot_reg == 2'd0) && bus.IN_less_than) ||
                ((slot_reg == 2'd1) && bus.IN_zero));
`else
  logic unused_flags;
  assign unused_flags = bus.IN_less_than ^ bus.IN_zero;
  assign dp = 1'b1;
`endif

  assign bus.OUT_seg = {dp, seg_sel};
  assign bus.OUT_an  = ~(4'b0001 << slot_reg);

endmodule

// File: doc/display_unit.md
DISPLAY_UNIT -- requirements
Module: display_unit

Interface
REQ-001 Parameter SCAN_DIV, default 16'd50000: IN_clk cycles per digit slot in the scan.
REQ-002 Clocking: one clock; reset is asynchronous and active-low.
REQ-003 IN_clk  input  1  rising-edge system clock.
REQ-004 IN_rst_n  input  1  asynchronous active-low reset.
REQ-005 IN_value  input  16  unsigned magnitude from the core stage.
REQ-006 IN_off_number  input  3  count of blanked leading digits, 0..4; values 5..7 are treated as 4.
REQ-007 IN_neg_ans  input  1  result negative; show a minus sign.
REQ-008 IN_less_than  input  1  compare result flag.
REQ-009 IN_zero  input  1  zero flag.
REQ-010 OUT_seg  output  8  active-low segments {dp,g,f,e,d,c,b,a}.
REQ-011 OUT_an  output  4  active-low digit enables; bit 3 is the leftmost digit.
REQ-012 OUT_busy  output  1  high while a BCD conversion is in progress.

Function
REQ-013 The block SHALL register {IN_value, IN_off_number, IN_neg_ans} every cycle in IDLE and start a conversion on the cycle after any of them differs from the last converted set.
REQ-014 States: IDLE -> CONV (16 shift-add-3 steps, one per cycle) -> LOAD (1 cycle) -> IDLE; OUT_busy SHALL be high in CONV and LOAD.
REQ-015 Latency from an input change to new digits driving OUT_seg SHALL be 18 cycles, plus up to one scan slot.
REQ-016 Inputs changing during CONV/LOAD SHALL be ignored until IDLE is reached, then compared again per REQ-013.
REQ-017 Displayed digits SHALL update only in LOAD; the previous digits SHALL be held during conversion (no flicker).
REQ-018 If IN_value > 9999, the four digits SHALL show "E" on all four positions, and the sign SHALL be suppressed.
REQ-019 Digit positions 3..(4-off_number) counted from the left SHALL be blanked (all segments off), with OUT_an still scanning.
REQ-020 If IN_neg_ans=1 and off_number>=1, the rightmost blanked position SHALL show "-" (g only).
REQ-021 If IN_neg_ans=1 and off_number=0, the display SHALL show "E" on all four positions.
REQ-022 Scan: a 16-bit divider counts 0..SCAN_DIV-1; on wrap, the slot index (2-bit) SHALL advance 3->2->1->0->3, with exactly one OUT_an bit low.
REQ-023 The dp segment SHALL be off in all positions unless overridden per REQ-027.
REQ-024 Segment encoding: 0x0-0x9 standard patterns; "E" = a,d,e,f,g; "-" = g; blank = all high.

Reset
REQ-025 On IN_rst_n=0, asynchronously: state=IDLE, OUT_seg=8'hFF, OUT_an=4'b0111, OUT_busy=0, divider=0, slot=3, all digit registers blank, last-converted set = {16'h0, 3'd4, 0}.
REQ-026 Reset asserted mid-CONV SHALL abort the conversion; after release, the block SHALL reconvert the current inputs per REQ-013.

Configuration
REQ-027 Macro DISP_FLAG_DP_EN defined: dp of digit 0 SHALL be lit when IN_less_than=1, dp of digit 1 SHALL be lit when IN_zero=1, both sampled live. Macro undefined: IN_less_than and IN_zero SHALL be unused and all dp off.

Verification
REQ-028 Reset, then value=1234, off=0, neg=0 -> busy high for 17 cycles; scan shows 1,2,3,4 left to right; digit 3 pattern = 8'hF9.
REQ-029 value=7, off=3, neg=1 -> positions show blank, blank, "-" (8'hBF), "7" (8'hF8).
REQ-030 value=10000, off=0 -> all four positions show 8'h86 ("E").
REQ-031 value changed from 5 to 6 at conversion cycle 8 -> the first conversion completes showing 5, then a second conversion starts and 6 is displayed 18 cycles after IDLE.
REQ-032 IN_rst_n pulsed low at CONV cycle 10 with value=42, off=2 -> outputs go to reset values immediately; after release, the display shows blank, blank, 4, 2.
REQ-033 With DISP_FLAG_DP_EN, less_than=1, zero=0 -> digit 0 segment bit 7 is low and digit 1 segment bit 7 is high; without the macro, both are high.
